// File: rtl/aes_decrypt_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_decrypt_iter -- iterative AES-128/192/256 inverse cipher, one round per clock.
// Rev 1.0. Optional macro AES_DECRYPT_ITER_KEY_LATCH_EN captures the key on accept.
// ----------------------------------------------------------------------------
module aes_decrypt_iter #(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NK*32-1:0]  key,
  input  logic [127:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [127:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  localparam int NR    = NK + 6;
  localparam int NW    = 4 * (NR + 1);
  localparam int CNT_W = $clog2(NR + 1);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_decrypt_iter: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, LAST = 2'd2, DONE = 2'd3} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // GF(2^8) inverse as a^254 via square-and-multiply; maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < j; k++) r = xtime(r);
    return r;
  endfunction

  // Byte i of the state sits at row i%4, column i/4; byte 0 is the MSB.
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_e             state_q, state_d;
  logic [127:0]       st_q, st_d;
  logic [CNT_W-1:0]   rnd_q, rnd_d;
  logic [127:0]       out_data_q, out_data_d;
  logic [NK*32-1:0]   kexp_key;
  logic [127:0]       rk [NR+1];
  logic [127:0]       rk_sel, sr_sb, ark, mix;

`ifdef AES_DECRYPT_ITER_KEY_LATCH_EN
  logic [NK*32-1:0] key_q, key_d;

  always_comb begin
    key_d = key_q;
    if (state_q == IDLE && in_valid) key_d = key;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_q <= '0;
    else        key_q <= key_d;
  end

  // The initial AddRoundKey happens on the accept edge, before key_q holds the new key.
  assign kexp_key = (state_q == IDLE) ? key : key_q;
`else
  assign kexp_key = key;
`endif

  always_comb begin : p_kexp
    logic [31:0] w [NW];
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        w[i] = kexp_key[NK*32-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % NK == 0)                t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / NK), 24'h0};
        else if (NK > 6 && i % NK == 4) t = sub_word(t);
        w[i] = w[i-NK] ^ t;
      end
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

  // The counter stays at 1 through LAST, so the final key is selected by state.
  assign rk_sel = (state_q == LAST) ? rk[0] : rk[rnd_q];
  assign sr_sb  = inv_sr_sb(st_q);
  assign ark    = sr_sb ^ rk_sel;
  assign mix    = inv_mix(ark);

  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    rnd_d      = rnd_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_data ^ rk[NR];
          rnd_d   = CNT_W'(NR - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d = mix;
        if (rnd_q == CNT_W'(1)) state_d = LAST;
        else                    rnd_d   = rnd_q - CNT_W'(1);
      end
      LAST: begin
        out_data_d = ark;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      st_q       <= '0;
      rnd_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      rnd_q      <= rnd_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == ROUND) || (state_q == LAST);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aes_decrypt_iter -- scoreboard bench: NK=4/6/8 instances, FIPS-197 vectors.
// Rev 1.0. Key-latch case runs only with AES_DECRYPT_ITER_KEY_LATCH_EN.
// ----------------------------------------------------------------------------
module tb_aes_decrypt_iter;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] kb;
  logic [127:0] idata [3];
  logic [127:0] od    [3];
  logic         iv    [3];
  logic         ir    [3];
  logic         ov    [3];
  logic         ordy  [3];
  logic         bsy   [3];
  logic [127:0] expq  [3][$];
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  aes_decrypt_iter #(.NK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .key(kb[255:128]), .in_data(idata[0]), .in_valid(iv[0]),
    .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bsy[0]));
  aes_decrypt_iter #(.NK(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .key(kb[255:64]), .in_data(idata[1]), .in_valid(iv[1]),
    .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bsy[1]));
  aes_decrypt_iter #(.NK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .key(kb), .in_data(idata[2]), .in_valid(iv[2]),
    .in_ready(ir[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .busy(bsy[2]));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual timeout required event", name);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input int g, input logic [127:0] d, input logic [127:0] e, input bit exp_out);
    if (exp_out) expq[g].push_back(e);
    idata[g] = d;
    iv[g]    = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (ir[g]) break;
      if (t == 299) fail_now($sformatf("send_timeout_dut%0d", g));
    end
    @(posedge clk);
    #1;
    iv[g]    = 1'b0;
    idata[g] = 'x;
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      #1;
      if (expq[0].size() == 0 && expq[1].size() == 0 && expq[2].size() == 0) return;
    end
    fail_now("drain_timeout");
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int NR_G = 10 + 2 * g;
    initial begin
      int   negn;
      int   acc_n;
      int   busy_n;
      logic prev_ov;
      negn    = 0;
      acc_n   = -1;
      busy_n  = 0;
      prev_ov = 1'b0;
      forever begin
        @(negedge clk);
        negn++;
        if (!rst_n) begin
          acc_n   = -1;
          prev_ov = 1'b0;
        end else begin
          if (acc_n >= 0 && bsy[g]) busy_n++;
          if (ov[g] && !prev_ov) begin
            if (expq[g].size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_out_dut%0d: actual %h required no output", g, od[g]);
            end else begin
              check($sformatf("data_nk%0d", 4 + 2 * g), od[g], expq[g].pop_front());
              check($sformatf("latency_nk%0d", 4 + 2 * g), 128'(negn - 1 - acc_n), 128'(NR_G));
              check($sformatf("busy_cycles_nk%0d", 4 + 2 * g), 128'(busy_n), 128'(NR_G));
            end
            acc_n = -1;
          end
          if (iv[g] && ir[g]) begin
            acc_n  = negn;
            busy_n = 0;
          end
          prev_ov = ov[g];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] held;
    kb = KEY;
    for (int g = 0; g < 3; g++) begin
      idata[g] = '0;
      iv[g]    = 1'b0;
      ordy[g]  = 1'b1;
    end

    @(negedge clk);
    check("reset_in_ready", 128'(ir[0]), 128'(1));
    check("reset_out_valid", 128'(ov[0]), 128'(0));
    check("reset_busy", 128'(bsy[0]), 128'(0));
    check("reset_out_data", od[0], 128'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(0, CT4, PT, 1'b1);
    send(1, CT6, PT, 1'b1);
    send(2, CT8, PT, 1'b1);
    drain();

    send(0, CT4, PT, 1'b1);
    send(0, CT4, PT, 1'b1);
    drain();

    // Backpressure: sink stalls for 20 cycles, source pokes in_valid meanwhile.
    ordy[0] = 1'b0;
    send(0, CT4, PT, 1'b1);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ov[0]) break;
      if (t == 39) fail_now("bp_wait_valid");
    end
    held = od[0];
    check("bp_first_data", held, PT);
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      iv[0]    = t[0];
      idata[0] = {4{32'hdeadbeef ^ 32'(t)}};
      @(negedge clk);
      check("bp_data_stable", od[0], PT);
      check("bp_in_ready_low", 128'(ir[0]), 128'(0));
      check("bp_out_valid_held", 128'(ov[0]), 128'(1));
    end
    @(posedge clk);
    #1;
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    @(negedge clk);
    check("bp_release_in_ready", 128'(ir[0]), 128'(1));
    check("bp_release_out_valid", 128'(ov[0]), 128'(0));
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;

    // Reset in the middle of a block: no output may appear for it.
    send(0, CT4, PT, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 128'(ov[0]), 128'(0));
    check("midreset_in_ready", 128'(ir[0]), 128'(1));
    check("midreset_busy", 128'(bsy[0]), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, CT4, PT, 1'b1);
    drain();

`ifdef AES_DECRYPT_ITER_KEY_LATCH_EN
    send(0, CT4, PT, 1'b1);
    @(posedge clk);
    #1;
    kb[255:128] = '1;
    drain();
    kb = KEY;
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
